// File: rtl/uart_tx_top.sv
// uart_tx_top: 8-bit UART transmitter, start bit, 8 data bits LSB first,
// optional parity bit, one stop bit. Every bit is held CLKS_PER_BIT cycles.
//
// Build option: define UART_TX_PARITY_EN to compile in the PARITY state and
// parity bit (11-bit frame). Without it the frame is 10 bits and PARITY_ODD
// has no effect.
//
// Handshake: a request is accepted in any cycle where tx_start=1 and
// tx_busy=0; tx_data_in is captured in that cycle. Requests while tx_busy=1
// are dropped, never queued. tx_done pulses in the last cycle of the stop bit.
module uart_tx_top #(
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data_in,
    output logic       tx_out,
    output logic       tx_busy,
    output logic       tx_done
);

    // Reject out-of-range parameters at elaboration time.
    if (CLKS_PER_BIT < 1 || CLKS_PER_BIT > 65535 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
        $error("uart_tx_top: CLKS_PER_BIT must be 1..65535 and PARITY_ODD 0 or 1");
    end

    // Last count value of a bit period, and the one before it (used to raise
    // tx_done one cycle ahead so it lands on the final stop cycle).
    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] PRE_LAST = 16'(CLKS_PER_BIT - 2);
    localparam logic        ONE_CLK  = (CLKS_PER_BIT == 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        ,
        PARITY = 3'd4
`endif
    } state_t;

    state_t      state;
    logic [15:0] bit_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_reg;
    logic        bit_end;

    assign bit_end = (bit_cnt == LAST_CNT);

`ifdef UART_TX_PARITY_EN
    logic parity_bit;
    // Parity comes from the latched byte, so later changes on tx_data_in are harmless.
    assign parity_bit = (^shift_reg) ^ (PARITY_ODD != 0);
`endif

    // Frame sequencer; all outputs are registered here alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tx_out    <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_start) begin
                        shift_reg <= tx_data_in;
                        bit_cnt   <= '0;
                        bit_idx   <= '0;
                        tx_out    <= 1'b0;
                        tx_busy   <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        tx_out  <= shift_reg[0];
                        state   <= DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx_out <= parity_bit;
                            state  <= PARITY;
`else
                            tx_out  <= 1'b1;
                            tx_done <= ONE_CLK;
                            state   <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx_out  <= shift_reg[bit_idx + 3'd1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        tx_out  <= 1'b1;
                        tx_done <= ONE_CLK;
                        state   <= STOP;
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        tx_out  <= 1'b1;
                        tx_busy <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                        tx_done <= (bit_cnt == PRE_LAST);
                    end
                end
                default: begin
                    tx_out  <= 1'b1;
                    tx_busy <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_top.sv
// tb_uart_tx_top: two transmitters (CLKS_PER_BIT=4 even parity, and
// CLKS_PER_BIT=1 odd parity) driven by directed stimulus. Expected frames
// are queued when a request is issued; a receiver-style monitor per DUT
// decodes tx_out and pops/compares independently.
module tb_uart_tx_top;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start4 = 1'b0, start1 = 1'b0;
    logic [7:0] data4 = 8'h00, data1 = 8'h00;
    logic       out4, busy4, done4, out1, busy1, done1;

    uart_tx_top #(.CLKS_PER_BIT(4), .PARITY_ODD(0)) dut4 (
        .clk(clk), .rst(rst), .tx_start(start4), .tx_data_in(data4),
        .tx_out(out4), .tx_busy(busy4), .tx_done(done4)
    );

    uart_tx_top #(.CLKS_PER_BIT(1), .PARITY_ODD(1)) dut1 (
        .clk(clk), .rst(rst), .tx_start(start1), .tx_data_in(data1),
        .tx_out(out1), .tx_busy(busy1), .tx_done(done1)
    );

`ifdef UART_TX_PARITY_EN
    localparam int NBITS  = 11;
    localparam bit PAR_EN = 1'b1;
`else
    localparam int NBITS  = 10;
    localparam bit PAR_EN = 1'b0;
`endif

    // ---------------- scoreboard state ----------------
    logic [10:0] exp4_q[$];
    logic [10:0] exp1_q[$];
    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int done_cnt4 = 0;
    int done_cnt1 = 0;
    int last_done4 = -1;
    int gap4 = -99;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done4 === 1'b1) done_cnt4 <= done_cnt4 + 1;
        if (done1 === 1'b1) done_cnt1 <= done_cnt1 + 1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: timed out waiting on DUT", name);
    endtask

    // Frame bits in transmit order: bit 0 is the start bit.
    function automatic logic [10:0] frame_of(input logic [7:0] d, input bit odd);
        logic [10:0] f;
        f      = '0;
        f[8:1] = d;
        if (PAR_EN) begin
            f[9]  = (^d) ^ odd;
            f[10] = 1'b1;
        end else begin
            f[9] = 1'b1;
        end
        return f;
    endfunction

    function automatic logic sig_out(input int w);
        return (w == 0) ? out4 : out1;
    endfunction
    function automatic logic sig_busy(input int w);
        return (w == 0) ? busy4 : busy1;
    endfunction
    function automatic logic sig_done(input int w);
        return (w == 0) ? done4 : done1;
    endfunction

    // ---------------- monitor (receiver model) ----------------
    task automatic run_monitor(input int w);
        int cpb;
        string nm;
        cpb = (w == 0) ? 4 : 1;
        nm  = (w == 0) ? "cpb4" : "cpb1";
        @(negedge clk);
        while (rst !== 1'b0) @(negedge clk);
        forever begin
            logic [10:0] got;
            logic [10:0] exp;
            bit shape_ok;
            bit aborted;
            int start_cyc;
            while (!(sig_busy(w) === 1'b1 && sig_out(w) === 1'b0)) @(negedge clk);
            start_cyc = cyc;
            if (w == 0 && last_done4 >= 0) gap4 = start_cyc - last_done4 - 1;
            got = '0;
            shape_ok = 1'b1;
            aborted = 1'b0;
            for (int b = 0; b < NBITS && !aborted; b++) begin
                for (int c = 0; c < cpb; c++) begin
                    if (b != 0 || c != 0) @(negedge clk);
                    if (rst === 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (c == 0) got[b] = sig_out(w);
                    else if (sig_out(w) !== got[b]) shape_ok = 1'b0;
                    if (sig_done(w) !== ((b == NBITS - 1) && (c == cpb - 1))) shape_ok = 1'b0;
                    if (sig_busy(w) !== 1'b1) shape_ok = 1'b0;
                end
            end
            if (aborted) begin
                if (w == 0) last_done4 = -1;
                while (rst !== 1'b0) @(negedge clk);
            end else begin
                if (w == 0) last_done4 = cyc;
                if ((w == 0 ? exp4_q.size() : exp1_q.size()) == 0) begin
                    n_checks++;
                    $display("FAIL %s_unexpected_frame: got frame 0x%0h expected none", nm, got);
                end else begin
                    exp = (w == 0) ? exp4_q.pop_front() : exp1_q.pop_front();
                    check({nm, "_frame_bits"}, 32'(got), 32'(exp));
                end
                check({nm, "_bit_timing_done"}, 32'(shape_ok), 32'd1);
                @(negedge clk);
                check({nm, "_idle_busy"}, 32'(sig_busy(w)), 32'd0);
                check({nm, "_idle_out"}, 32'(sig_out(w)), 32'd1);
                check({nm, "_idle_done"}, 32'(sig_done(w)), 32'd0);
                @(negedge clk);
            end
        end
    endtask

    initial run_monitor(0);
    initial run_monitor(1);

    // ---------------- driver tasks ----------------
    // Waits for the DUT to be idle, then presents one request for one cycle.
    task automatic send(input int w, input logic [7:0] d, input bit push);
        int t;
        t = 0;
        @(posedge clk);
        #1;
        while (sig_busy(w) !== 1'b0 && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 2000) fail_now("send_wait_idle");
        if (w == 0) begin
            start4 = 1'b1;
            data4  = d;
            if (push) exp4_q.push_back(frame_of(d, 1'b0));
        end else begin
            start1 = 1'b1;
            data1  = d;
            if (push) exp1_q.push_back(frame_of(d, 1'b1));
        end
        @(posedge clk);
        #1;
        if (w == 0) begin
            start4 = 1'b0;
            data4  = ~d;
        end else begin
            start1 = 1'b0;
            data1  = ~d;
        end
    endtask

    task automatic drain(input int w);
        int t;
        t = 0;
        while (((w == 0) ? (exp4_q.size() != 0 || busy4 !== 1'b0)
                         : (exp1_q.size() != 0 || busy1 !== 1'b0)) && t < 3000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 3000) fail_now("drain");
        repeat (3) @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int d0;
        int t;
        // Reset held with tx_start high: reset must win.
        rst = 1'b1;
        start4 = 1'b1; data4 = 8'hA5;
        start1 = 1'b1; data1 = 8'hFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out4", 32'(out4), 32'd1);
        check("rst_busy4", 32'(busy4), 32'd0);
        check("rst_done4", 32'(done4), 32'd0);
        check("rst_out1", 32'(out1), 32'd1);
        check("rst_busy1", 32'(busy1), 32'd0);
        check("rst_done1", 32'(done1), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        start4 = 1'b0;
        start1 = 1'b0;

        // Basic frames on both instances.
        send(0, 8'hA5, 1'b1);
        send(1, 8'hFF, 1'b1);
        drain(0);
        drain(1);

        // Request during a frame is ignored; only one tx_done.
        d0 = done_cnt4;
        send(0, 8'h5A, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        start4 = 1'b1;
        data4  = 8'h3C;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        drain(0);
        repeat (20) @(posedge clk);
        #1;
        check("ignored_req_done_count", 32'(done_cnt4 - d0), 32'd1);

        // Parity sense on a single set bit (even on dut4, odd on dut1).
        send(0, 8'h01, 1'b1);
        send(1, 8'h01, 1'b1);
        send(1, 8'h3C, 1'b1);
        drain(0);
        drain(1);

        // Reset during DATA bit 3 of 0x55 aborts the frame.
        d0 = done_cnt4;
        send(0, 8'h55, 1'b0);
        repeat (17) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_out", 32'(out4), 32'd1);
        check("abort_busy", 32'(busy4), 32'd0);
        check("abort_done", 32'(done4), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        check("abort_no_done", 32'(done_cnt4 - d0), 32'd0);
        send(0, 8'h55, 1'b1);
        drain(0);

        // tx_start held high: 0x00 then 0xFF, one idle cycle between.
        gap4 = -99;
        start4 = 1'b1;
        data4  = 8'h00;
        exp4_q.push_back(frame_of(8'h00, 1'b0));
        @(posedge clk);
        #1;
        data4 = 8'hFF;
        exp4_q.push_back(frame_of(8'hFF, 1'b0));
        t = 0;
        @(negedge clk);
        while (done4 !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) fail_now("b2b_wait_done");
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        drain(0);
        check("b2b_idle_gap", 32'(gap4), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time limit.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_top.md
UART_TX_TOP -- requirements
Module: uart_tx_top

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4, meaning clock cycles each serial bit is held on tx_out; legal range 1..65535.
REQ-002 Parameter PARITY_ODD, default 0, meaning parity sense: 0 = even, 1 = odd; used only when UART_TX_PARITY_EN is defined.
REQ-003 Port clk  input  1  rising-edge clock for all state.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port tx_start  input  1  request to send tx_data_in; sampled every cycle.
REQ-006 Port tx_data_in  input  8  byte to transmit; sampled only on an accepted request.
REQ-007 Port tx_out  output  1  serial line; idle/mark level 1.
REQ-008 Port tx_busy  output  1  high while a frame is in progress; a request is accepted only when low.
REQ-009 Port tx_done  output  1  one-cycle pulse marking the last cycle of the stop bit.

Function
REQ-010 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP; PARITY is absent when UART_TX_PARITY_EN is undefined.
REQ-011 Acceptance SHALL occur in any cycle with tx_start=1 and tx_busy=0; tx_data_in is latched into an 8-bit shift register in that cycle.
REQ-012 Requests with tx_busy=1 SHALL be ignored, with no effect on the frame in flight and no queuing.
REQ-013 From the cycle after acceptance, tx_out SHALL drive start bit 0 and tx_busy SHALL be 1, both registered outputs.
REQ-014 Each frame bit SHALL be held exactly CLKS_PER_BIT cycles, timed by a bit-period counter that resets at every bit boundary.
REQ-015 DATA SHALL send the 8 latched bits LSB first, with a 3-bit index counter that reaches 7 before leaving DATA.
REQ-016 PARITY SHALL send the XOR of the 8 latched bits, inverted when PARITY_ODD=1, computed from the latched copy and not from tx_data_in.
REQ-017 STOP SHALL send 1 for CLKS_PER_BIT cycles.
REQ-018 tx_done SHALL be 1 only in the final cycle of STOP.
REQ-019 The next cycle after tx_done SHALL return the FSM to IDLE with tx_busy=0 and tx_out=1.
REQ-020 Frame length SHALL be 11*CLKS_PER_BIT cycles with parity and 10*CLKS_PER_BIT cycles without.
REQ-021 Back-to-back operation: a request in the first IDLE cycle after tx_done SHALL be accepted, giving exactly one idle cycle between frames.
REQ-022 Changes on tx_data_in after acceptance SHALL NOT affect the frame in flight.
REQ-023 With CLKS_PER_BIT=1, each bit SHALL occupy exactly one cycle and behaviour SHALL otherwise be unchanged.

Reset
REQ-024 rst=1 at a clock edge SHALL force, on the next cycle: state IDLE, tx_out=1, tx_busy=0, tx_done=0, all counters 0, shift register 0.
REQ-025 Reset SHALL take priority over tx_start in the same cycle.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately, without emitting tx_done.

Configuration
REQ-027 Macro UART_TX_PARITY_EN defined: the PARITY state and parity bit SHALL be compiled in, giving an 11-bit frame that matches the receiver's parity and stop checks.
REQ-028 Macro UART_TX_PARITY_EN undefined: PARITY logic SHALL be absent, DATA SHALL go directly to STOP, giving a 10-bit frame; PARITY_ODD is ignored.

Verification
REQ-029 Parity enabled, CLKS_PER_BIT=4, send 0xA5 -> tx_out = 0,1,0,1,0,0,1,0,1,0,1, each for 4 cycles; tx_done at cycle 44 after acceptance; tx_busy low at cycle 45.
REQ-030 Parity enabled, PARITY_ODD=0, send 0x01 -> parity bit 1; with PARITY_ODD=1 -> parity bit 0.
REQ-031 Parity disabled, CLKS_PER_BIT=1, send 0xFF -> tx_out = 0,1,1,1,1,1,1,1,1,1; tx_done 10 cycles after acceptance.
REQ-032 tx_start pulsed with 0x3C during a frame of 0x5A -> 0x5A frame intact; no second frame; tx_done pulses once.
REQ-033 rst asserted in DATA bit 3 of 0x55 -> next cycle tx_out=1, tx_busy=0, no tx_done; a new request afterwards sends a correct full frame.
REQ-034 tx_start held high continuously with 0x00 then 0xFF -> frames separated by exactly one idle cycle, both byte-correct as decoded by the RX_top receiver model.
